// File: rtl/core_mem_pkg.sv
// Shared memory-stage constants: load/store funct3 encodings, region codes and
// the address bits used to pick a region.
package core_mem_pkg;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    localparam logic [1:0] REG_NONE = 2'd0;
    localparam logic [1:0] REG_DMEM = 2'd1;
    localparam logic [1:0] REG_BIOS = 2'd2;
    localparam logic [1:0] REG_MMIO = 2'd3;

    localparam int unsigned MMIO_BIT = 31;
    localparam int unsigned BIOS_BIT = 30;
    localparam int unsigned DMEM_BIT = 28;

    typedef struct packed {
        logic       valid;
        logic [2:0] funct3;
        logic [1:0] off;
        logic [4:0] rd;
        logic [1:0] region;
        logic       err;
    } load_stage_t;

endpackage

// File: rtl/load_extend.sv
// Byte/halfword/word extraction with sign or zero extension for loads.
module load_extend
    import core_mem_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] word,
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    output logic [DWIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*off +: 8];
        half_sel = word[16*off[1] +: 16];
        data     = '0;
        case (funct3)
            FNC_LB:  data = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            FNC_LBU: data = {{(DWIDTH-8){1'b0}}, byte_sel};
            FNC_LH:  data = {{(DWIDTH-16){half_sel[15]}}, half_sel};
            FNC_LHU: data = {{(DWIDTH-16){1'b0}}, half_sel};
            FNC_LW:  data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load response path: tracks requests through the memory latency, selects the
// source memory, aligns and extends the result, and flags bad loads.
module load_align_unit
    import core_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              req_valid,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [4:0]        req_rd,
    input  logic [DWIDTH-1:0] dmem_dout,
    input  logic [DWIDTH-1:0] bios_dout,
    input  logic [DWIDTH-1:0] mmio_dout,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic [2:0]        inflight
);

    load_stage_t stage_q [LATENCY];
    load_stage_t cap;
    load_stage_t last;
    logic [DWIDTH-1:0] dout_sel;
    logic [DWIDTH-1:0] ext_data;
    logic              addr_unused;

    // Only a few address bits matter here; fold the rest away.
    assign addr_unused = ^req_addr;

    always_comb begin
        cap = '0;
        if (req_valid) begin
            cap.valid  = 1'b1;
            cap.funct3 = req_funct3;
            cap.off    = req_addr[1:0];
            cap.rd     = req_rd;
            if (req_addr[MMIO_BIT])      cap.region = REG_MMIO;
            else if (req_addr[BIOS_BIT]) cap.region = REG_BIOS;
            else if (req_addr[DMEM_BIT]) cap.region = REG_DMEM;
            else                         cap.region = REG_NONE;
            case (req_funct3)
                FNC_LB, FNC_LBU: cap.err = 1'b0;
                FNC_LH, FNC_LHU: cap.err = req_addr[0];
                FNC_LW:          cap.err = |req_addr[1:0];
                default:         cap.err = 1'b1;
            endcase
            if (cap.region == REG_NONE) cap.err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
        end else if (!stall) begin
            stage_q[0] <= cap;
            for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + 3'(stage_q[i].valid);
    end

    assign last = stage_q[LATENCY-1];

    always_comb begin
        dout_sel = '0;
        case (last.region)
            REG_DMEM: dout_sel = dmem_dout;
            REG_BIOS: dout_sel = bios_dout;
            REG_MMIO: dout_sel = mmio_dout;
            default:  dout_sel = '0;
        endcase
    end

    load_extend #(
        .DWIDTH(DWIDTH)
    ) u_extend (
        .word  (dout_sel),
        .funct3(last.funct3),
        .off   (last.off),
        .data  (ext_data)
    );

    assign rsp_valid = last.valid;
    assign rsp_rd    = last.rd;
    assign rsp_err   = last.valid & last.err;
    assign rsp_data  = (last.valid && !last.err) ? ext_data : '0;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench: two instances (LATENCY 1 and 2) fed by a bench memory model.
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [4:0]  req_rd = '0;
    logic [31:0] in_dmem = '0, in_bios = '0, in_mmio = '0;
    logic [31:0] m1_dmem, m1_bios, m1_mmio, m2_dmem, m2_bios, m2_mmio;

    logic        r1_valid, r1_err, r2_valid, r2_err;
    logic [31:0] r1_data, r2_data;
    logic [4:0]  r1_rd, r2_rd;
    logic [2:0]  r1_inflight, r2_inflight;

    typedef struct packed {
        logic [4:0]  rd;
        logic        err;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] dmem;
        logic [31:0] bios;
        logic [31:0] mmio;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    // Synchronous memories enabled with ~stall, one and two read stages deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_dmem <= '0; m1_bios <= '0; m1_mmio <= '0;
            m2_dmem <= '0; m2_bios <= '0; m2_mmio <= '0;
        end else if (!stall) begin
            m1_dmem <= in_dmem; m1_bios <= in_bios; m1_mmio <= in_mmio;
            m2_dmem <= m1_dmem; m2_bios <= m1_bios; m2_mmio <= m1_mmio;
        end
    end

    load_align_unit #(.LATENCY(1), .AWIDTH(32), .DWIDTH(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .req_valid(req_valid),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_rd(req_rd),
        .dmem_dout(m1_dmem), .bios_dout(m1_bios), .mmio_dout(m1_mmio),
        .rsp_valid(r1_valid), .rsp_data(r1_data), .rsp_rd(r1_rd), .rsp_err(r1_err),
        .inflight(r1_inflight)
    );

    load_align_unit #(.LATENCY(2), .AWIDTH(32), .DWIDTH(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .req_valid(req_valid),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_rd(req_rd),
        .dmem_dout(m2_dmem), .bios_dout(m2_bios), .mmio_dout(m2_mmio),
        .rsp_valid(r2_valid), .rsp_data(r2_data), .rsp_rd(r2_rd), .rsp_err(r2_err),
        .inflight(r2_inflight)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    task automatic check_rsp(input string name, input logic [4:0] rd, input logic err,
                             input logic [31:0] data, input exp_t e);
        n_total++;
        if (rd === e.rd && err === e.err && data === e.data) n_pass++;
        else $display("FAIL %s: got rd=%0d err=%0b data=%h, want rd=%0d err=%0b data=%h",
                      name, rd, err, data, e.rd, e.err, e.data);
    endtask

    // Monitor: compare every presented response; retire it on a non-stalled edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (r1_valid) begin
                if (q1.size() == 0) check("lat1_unexpected_rsp", 64'(r1_rd), 64'h0);
                else begin
                    check_rsp("lat1_rsp", r1_rd, r1_err, r1_data, q1[0]);
                    if (!stall) void'(q1.pop_front());
                end
            end
            if (r2_valid) begin
                if (q2.size() == 0) check("lat2_unexpected_rsp", 64'(r2_rd), 64'h0);
                else begin
                    check_rsp("lat2_rsp", r2_rd, r2_err, r2_data, q2[0]);
                    if (!stall) void'(q2.pop_front());
                end
            end
        end
    end

    function automatic vec_t mk(input logic [31:0] addr, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [31:0] dmem,
                                input logic [31:0] bios, input logic [31:0] mmio,
                                input logic [31:0] exp_data, input logic exp_err);
        vec_t v;
        v.addr = addr; v.f3 = f3; v.rd = rd; v.dmem = dmem; v.bios = bios;
        v.mmio = mmio; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic issue(input vec_t v, input int nstall);
        exp_t e;
        e.rd = v.rd; e.err = v.exp_err; e.data = v.exp_data;
        q1.push_back(e);
        q2.push_back(e);
        req_valid = 1'b1; req_addr = v.addr; req_funct3 = v.f3; req_rd = v.rd;
        in_dmem = v.dmem; in_bios = v.bios; in_mmio = v.mmio;
        stall = (nstall > 0);
        for (int i = 0; i < nstall; i++) begin
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
        in_dmem = '0; in_bios = '0; in_mmio = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk(32'h1000_0003, 3'b000, 5'd1, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 0));
        vecs.push_back(mk(32'h1000_0002, 3'b101, 5'd2, 32'h8001_0000, 0, 0, 32'h0000_8001, 0));
        vecs.push_back(mk(32'h1000_0002, 3'b001, 5'd3, 32'h8001_0000, 0, 0, 32'hFFFF_8001, 0));
        vecs.push_back(mk(32'h4000_0000, 3'b010, 5'd4, 32'h1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(32'h8000_0010, 3'b010, 5'd8, 0, 0, 32'h1234_5678, 32'h1234_5678, 0));
        vecs.push_back(mk(32'h1000_0002, 3'b010, 5'd9, 32'hFFFF_FFFF, 0, 0, 32'h0, 1));
        vecs.push_back(mk(32'h1000_0001, 3'b001, 5'd10, 32'hFFFF_FFFF, 0, 0, 32'h0, 1));
        vecs.push_back(mk(32'h1000_0000, 3'b011, 5'd11, 32'hFFFF_FFFF, 0, 0, 32'h0, 1));
        vecs.push_back(mk(32'h0000_0100, 3'b010, 5'd12, 32'hFFFF_FFFF, 0, 0, 32'h0, 1));
        vecs.push_back(mk(32'h1000_0001, 3'b100, 5'd13, 32'h0000_A500, 0, 0, 32'h0000_00A5, 0));
        vecs.push_back(mk(32'h4000_0002, 3'b000, 5'd14, 0, 32'h007F_0000, 0, 32'h0000_007F, 0));
        vecs.push_back(mk(32'hD000_0000, 3'b010, 5'd15, 32'h22, 32'h11, 32'hCAFE_F00D,
                          32'hCAFE_F00D, 0));
        vecs.push_back(mk(32'h1000_0000, 3'b110, 5'd16, 32'h1, 0, 0, 32'h0, 1));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 64'({r1_valid, r2_valid}), 64'h0);
        check("reset_inflight", 64'({r1_inflight, r2_inflight}), 64'h0);
        check("reset_rd_err_data", 64'({r1_rd, r2_rd, r1_err, r2_err, r1_data}), 64'h0);
        rst_n = 1'b1;
        idle(2);

        // Directed single loads, isolated.
        foreach (vecs[i]) begin
            issue(vecs[i], 0);
            idle(2);
        end

        // Back-to-back with a held request across a 3-cycle stall.
        issue(mk(32'h1000_0004, 3'b010, 5'd5, 32'h55, 0, 0, 32'h55, 0), 0);
        issue(mk(32'h1000_0004, 3'b010, 5'd6, 32'h66, 0, 0, 32'h66, 0), 0);
        check("b2b_inflight_lat2", 64'(r2_inflight), 64'd2);
        check("b2b_inflight_lat1", 64'(r1_inflight), 64'd1);
        issue(mk(32'h1000_0004, 3'b010, 5'd7, 32'h77, 0, 0, 32'h77, 0), 3);
        check("b2b_inflight_after_stall", 64'(r2_inflight), 64'd2);
        idle(4);
        check("drain_after_stall", 64'(q1.size() + q2.size()), 64'd0);

        // Asynchronous reset with two loads in flight.
        issue(mk(32'h1000_0000, 3'b010, 5'd20, 32'hAAAA, 0, 0, 32'hAAAA, 0), 0);
        issue(mk(32'h1000_0000, 3'b010, 5'd21, 32'hBBBB, 0, 0, 32'hBBBB, 0), 0);
        req_valid = 1'b0;
        check("pre_reset_inflight", 64'(r2_inflight), 64'd2);
        #2 rst_n = 1'b0;
        q1.delete();
        q2.delete();
        #1;
        check("async_reset_valid", 64'({r1_valid, r2_valid}), 64'h0);
        check("async_reset_inflight", 64'({r1_inflight, r2_inflight}), 64'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(5);
        check("post_reset_quiet", 64'({r1_valid, r2_valid, r1_inflight, r2_inflight}), 64'h0);

        // One more load after reset to show the unit recovers.
        issue(mk(32'h1000_0002, 3'b100, 5'd22, 32'h00C3_0000, 0, 0, 32'h0000_00C3, 0), 0);
        idle(10);
        check("final_drain", 64'(q1.size() + q2.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Read-side counterpart of the store byte-enable logic in the RISC-V core's memory stage. Accepts a load request (address, funct3, destination register), tracks it through a parameterised synchronous memory read latency, then selects the source memory (DMEM / BIOS / MMIO) from the registered address. It extracts the addressed byte, halfword or word, applies sign or zero extension, and presents a 32-bit writeback value with the destination tag. It also flags misaligned, illegal-funct3 and unmapped loads, and reports the in-flight load count for hazard logic.

Parameters:
LATENCY, 1, memory read latency in cycles (1..4); pipeline depth of the request tracker
AWIDTH, 32, address width
DWIDTH, 32, data width (fixed 32; parameter for readability only)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  freeze all tracker stages; memories are enabled with ~stall
req_valid  input  1  load issued this cycle
req_addr  input  AWIDTH  byte address of load
req_funct3  input  3  RISC-V load funct3 (LB/LH/LW/LBU/LHU)
req_rd  input  5  destination register tag
dmem_dout  input  DWIDTH  DMEM read word, valid LATENCY cycles after request
bios_dout  input  DWIDTH  BIOS read word, same timing
mmio_dout  input  DWIDTH  MMIO read word, same timing
rsp_valid  output  1  response valid (registered)
rsp_data  output  DWIDTH  extended load result
rsp_rd  output  5  destination tag of response
rsp_err  output  1  misaligned / illegal funct3 / unmapped; rsp_data forced to 0
inflight  output  3  number of valid tracker stages (0..LATENCY)

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low (rst_n).
- Reset: all stage valid bits 0, hence rsp_valid=0 and inflight=0. rsp_rd=0; rsp_data=0 and rsp_err=0 whenever rsp_valid=0.
- Reset mid-operation: in-flight loads are discarded immediately. No response is produced for them after reset release.
- Tracker: shift register of LATENCY stages.
  - Each stage holds valid, funct3, addr[1:0], rd, region (2 bits) and err.
  - Stage 0 captures the request on a clock edge where stall=0. req_valid=0 captures a bubble.
- Timing: a request issued at edge N, with no stall, gives rsp_valid=1 in the cycle after edge N+LATENCY-1. Latency is LATENCY cycles.
- Stall:
  - While stall=1 every stage holds, including stage LATENCY-1, so rsp_valid and rsp_data remain stable.
  - Requests presented during stall are ignored. The issuer must hold them.
- Region decode at capture time, evaluated in priority order:
  1. addr[31]=1 gives MMIO.
  2. Otherwise addr[30]=1 gives BIOS.
  3. Otherwise addr[28]=1 gives DMEM.
  4. Otherwise the region is unmapped and err=1.
- Error at capture time:
  - Illegal funct3 (3'b011, 3'b110, 3'b111) sets err=1.
  - LH/LHU with addr[0]=1 sets err=1.
  - LW with addr[1:0]!=0 sets err=1.
- Extraction uses the final-stage fields and the selected dout, combinationally from registered control and memory output.
  - LB/LBU: byte = word[8*off +: 8]. LB sign-extends bit 7; LBU zero-extends.
  - LH/LHU: half = word[16*off[1] +: 16]. LH sign-extends bit 15; LHU zero-extends.
  - LW: full word.
- Error response: err=1 gives rsp_err=1 and rsp_data=0. rsp_valid is still asserted so writeback can trap.
- inflight: popcount of stage valid bits. Back-to-back requests every cycle give inflight=LATENCY in steady state.

Decomposition:
- Shared package core_mem_pkg:
  - FNC_LB/LH/LW/LBU/LHU and FNC_SB/SH/SW constants (also consumed by the store side)
  - region encoding constants REG_NONE/DMEM/BIOS/MMIO
  - region address-bit positions
- Sub-module load_extend (combinational): inputs word, funct3, off[1:0]; output extended data. Instantiated once at the tracker output.

Test Plan:
- LATENCY=1; LB at 0x1000_0003 with dmem_dout=0x80FF_1234 -> next cycle rsp_valid=1, rsp_data=0xFFFF_FF80, rsp_err=0.
- LHU at 0x1000_0002 with dmem_dout=0x8001_0000 -> rsp_data=0x0000_8001. LH at the same address -> rsp_data=0xFFFF_8001.
- LW at 0x4000_0000 (BIOS) with bios_dout=0xDEAD_BEEF and dmem_dout=0x1 -> rsp_data=0xDEAD_BEEF. LW at 0x8000_0010 -> mmio_dout passed through.
- Errors, each with rsp_valid=1, rsp_err=1, rsp_data=0:
  - LW at 0x1000_0002
  - LH at 0x1000_0001
  - funct3=3'b011
  - LW at 0x0000_0100 (unmapped)
- LATENCY=2: three back-to-back loads with rd=5,6,7 -> inflight reaches 2 and responses arrive in order 5,6,7. Assert stall for 3 cycles mid-stream -> rsp_* frozen, no request lost or duplicated.
- Assert rst_n=0 asynchronously while 2 loads are in flight -> rsp_valid=0 and inflight=0 immediately, no stale response after release.
